// File: rtl/retire_stage.sv
// retire_stage: in-order retirement from the ROB head, up to N entries per cycle.
// Retires the leading run of complete head slots, publishes architectural map
// writes and frees previous physical registers in the same cycle, and handles
// mispredict flush/recovery and halt.
// Optional feature macro: RETIRE_PERF_CNT_EN (retired_count / stall_cycles counters).
module retire_stage #(
    parameter int unsigned N              = 3,
    parameter int unsigned ARCH_BITS      = 5,
    parameter int unsigned PHYS_BITS      = 6,
    parameter int unsigned RECOVER_CYCLES = 2,
    localparam int unsigned CNT_BITS      = $clog2(N + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CNT_BITS-1:0]    rob_outputs_valid,
    input  logic [N-1:0]           head_complete,
    input  logic [N-1:0]           head_mispredict,
    input  logic [N-1:0]           head_halt,
    input  logic [N*ARCH_BITS-1:0] head_dest_arch,
    input  logic [N*PHYS_BITS-1:0] head_dest_phys,
    input  logic [N*PHYS_BITS-1:0] head_prev_phys,
    input  logic [N*32-1:0]        head_target_pc,
    output logic [CNT_BITS-1:0]    num_retiring,
    output logic [N-1:0]           map_we,
    output logic [N*ARCH_BITS-1:0] map_arch,
    output logic [N*PHYS_BITS-1:0] map_phys,
    output logic [N-1:0]           free_valid,
    output logic [N*PHYS_BITS-1:0] free_phys,
    output logic                   flush,
    output logic [31:0]            redirect_pc,
    output logic                   halted,
    output logic [63:0]            retired_count,
    output logic [31:0]            stall_cycles
);

    localparam int unsigned         RCNT_BITS = 4;
    localparam logic [CNT_BITS-1:0] N_CNT     = CNT_BITS'(N);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t                 state;
    logic [RCNT_BITS-1:0]   recover_cnt;

    logic [CNT_BITS-1:0]    valid_eff;
    logic                   retire_en;
    logic [N-1:0]           retire_slot;
    logic [CNT_BITS-1:0]    retire_cnt;
    logic                   halt_hit;
    logic                   mispredict_hit;
    logic [31:0]            mispredict_pc;
    logic                   scanning;

    // Clamp the ROB valid count to the retire width; reset and non-RUN states block retirement
    always_comb begin
        valid_eff = (rob_outputs_valid > N_CNT) ? N_CNT : rob_outputs_valid;
        retire_en = (state == RUN) && !reset;
    end

    // Scan head slots oldest-first; stop at the first incomplete slot or after a halt/mispredict
    always_comb begin
        retire_slot    = '0;
        retire_cnt     = '0;
        halt_hit       = 1'b0;
        mispredict_hit = 1'b0;
        mispredict_pc  = '0;
        scanning       = retire_en;
        for (int unsigned i = 0; i < N; i++) begin
            if (scanning && (CNT_BITS'(i) < valid_eff) && head_complete[i]) begin
                retire_slot[i] = 1'b1;
                retire_cnt     = retire_cnt + CNT_BITS'(1);
                if (head_halt[i]) begin
                    // halt wins over a mispredict flagged in the same slot
                    halt_hit = 1'b1;
                    scanning = 1'b0;
                end else if (head_mispredict[i]) begin
                    mispredict_hit = 1'b1;
                    mispredict_pc  = head_target_pc[i*32 +: 32];
                    scanning       = 1'b0;
                end
            end else begin
                scanning = 1'b0;
            end
        end
    end

    // Same-cycle map table writes and free-list returns for retiring slots with a destination
    always_comb begin
        num_retiring = retire_cnt;
        map_we       = '0;
        map_arch     = '0;
        map_phys     = '0;
        free_valid   = '0;
        free_phys    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (retire_slot[i] && (head_dest_arch[i*ARCH_BITS +: ARCH_BITS] != '0)) begin
                map_we[i]                         = 1'b1;
                map_arch[i*ARCH_BITS +: ARCH_BITS] = head_dest_arch[i*ARCH_BITS +: ARCH_BITS];
                map_phys[i*PHYS_BITS +: PHYS_BITS] = head_dest_phys[i*PHYS_BITS +: PHYS_BITS];
                free_valid[i]                     = 1'b1;
                free_phys[i*PHYS_BITS +: PHYS_BITS] = head_prev_phys[i*PHYS_BITS +: PHYS_BITS];
            end
        end
    end

    // Control FSM: flush pulse and redirect on mispredict, timed recovery, sticky halt
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            recover_cnt <= '0;
            flush       <= 1'b0;
            redirect_pc <= '0;
            halted      <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                RUN: begin
                    if (halt_hit) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (mispredict_hit) begin
                        state       <= RECOVER;
                        recover_cnt <= RCNT_BITS'(RECOVER_CYCLES);
                        flush       <= 1'b1;
                        redirect_pc <= mispredict_pc;
                    end
                end
                RECOVER: begin
                    if (recover_cnt <= RCNT_BITS'(1)) begin
                        state       <= RUN;
                        recover_cnt <= '0;
                    end else begin
                        recover_cnt <= recover_cnt - RCNT_BITS'(1);
                    end
                end
                HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef RETIRE_PERF_CNT_EN
    // Performance counters: total retired entries and head-blocked RUN cycles, both wrapping
    always_ff @(posedge clock) begin
        if (reset) begin
            retired_count <= '0;
            stall_cycles  <= '0;
        end else begin
            retired_count <= retired_count + 64'(retire_cnt);
            if ((state == RUN) && (rob_outputs_valid != '0) && (retire_cnt == '0)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`else
    assign retired_count = '0;
    assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Self-checking bench for retire_stage: directed scenarios followed by random
// traffic, compared every cycle against a behavioural reference model.
module tb_retire_stage;

    localparam int N  = 3;
    localparam int AB = 5;
    localparam int PB = 6;
    localparam int RC = 2;
    localparam int CB = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [CB-1:0]     rob_outputs_valid;
    logic [N-1:0]      head_complete;
    logic [N-1:0]      head_mispredict;
    logic [N-1:0]      head_halt;
    logic [N*AB-1:0]   head_dest_arch;
    logic [N*PB-1:0]   head_dest_phys;
    logic [N*PB-1:0]   head_prev_phys;
    logic [N*32-1:0]   head_target_pc;
    logic [CB-1:0]     num_retiring;
    logic [N-1:0]      map_we;
    logic [N*AB-1:0]   map_arch;
    logic [N*PB-1:0]   map_phys;
    logic [N-1:0]      free_valid;
    logic [N*PB-1:0]   free_phys;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic              halted;
    logic [63:0]       retired_count;
    logic [31:0]       stall_cycles;

    retire_stage #(.N(N), .ARCH_BITS(AB), .PHYS_BITS(PB), .RECOVER_CYCLES(RC)) dut (
        .clock(clock), .reset(reset),
        .rob_outputs_valid(rob_outputs_valid),
        .head_complete(head_complete), .head_mispredict(head_mispredict), .head_halt(head_halt),
        .head_dest_arch(head_dest_arch), .head_dest_phys(head_dest_phys),
        .head_prev_phys(head_prev_phys), .head_target_pc(head_target_pc),
        .num_retiring(num_retiring), .map_we(map_we), .map_arch(map_arch), .map_phys(map_phys),
        .free_valid(free_valid), .free_phys(free_phys),
        .flush(flush), .redirect_pc(redirect_pc), .halted(halted),
        .retired_count(retired_count), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // stimulus as plain arrays
    int          v;
    bit          cmp [N];
    bit          mis [N];
    bit          hlt [N];
    int          d_arch [N];
    int          d_phys [N];
    int          p_phys [N];
    logic [31:0] tgt [N];

    // reference model state: mode 0=RUN 1=RECOVER 2=HALTED
    int          m_mode = 0;
    int          m_rec = 0;
    logic        m_flush = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_halted = 1'b0;
    logic [63:0] m_ret = '0;
    logic [31:0] m_stall = '0;
    bit          m_known = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        rob_outputs_valid = CB'(v);
        for (int i = 0; i < N; i++) begin
            head_complete[i]             = cmp[i];
            head_mispredict[i]           = mis[i];
            head_halt[i]                 = hlt[i];
            head_dest_arch[i*AB +: AB]   = AB'(d_arch[i]);
            head_dest_phys[i*PB +: PB]   = PB'(d_phys[i]);
            head_prev_phys[i*PB +: PB]   = PB'(p_phys[i]);
            head_target_pc[i*32 +: 32]   = tgt[i];
        end
    endtask

    task automatic drive(input int valid, input bit [2:0] c, input bit [2:0] m, input bit [2:0] h);
        v = valid;
        for (int i = 0; i < N; i++) begin
            cmp[i] = c[i];
            mis[i] = m[i];
            hlt[i] = h[i];
        end
        pack();
    endtask

    task automatic set_dest(input int i, input int a, input int d, input int p, input logic [31:0] t);
        d_arch[i] = a;
        d_phys[i] = d;
        p_phys[i] = p;
        tgt[i]    = t;
        pack();
    endtask

    // Oldest-first: count complete heads within the valid window, ending after a halt or mispredict
    function automatic int model_retire(output bit hev, output bit mev, output logic [31:0] pc);
        int lim;
        int n;
        hev = 1'b0;
        mev = 1'b0;
        pc  = '0;
        n   = 0;
        if (reset || m_mode != 0) return 0;
        lim = (v > N) ? N : v;
        for (int i = 0; i < lim; i++) begin
            if (!cmp[i]) break;
            n++;
            if (hlt[i]) begin hev = 1'b1; break; end
            if (mis[i]) begin mev = 1'b1; pc = tgt[i]; break; end
        end
        return n;
    endfunction

    task automatic check_now();
        int          n;
        bit          hev, mev;
        logic [31:0] pc;
        logic [N-1:0]    e_we;
        logic [N*AB-1:0] e_arch;
        logic [N*PB-1:0] e_phys, e_free;
        #3;
        n = model_retire(hev, mev, pc);
        e_we = '0; e_arch = '0; e_phys = '0; e_free = '0;
        for (int i = 0; i < n; i++) begin
            if (d_arch[i] != 0) begin
                e_we[i]             = 1'b1;
                e_arch[i*AB +: AB]  = AB'(d_arch[i]);
                e_phys[i*PB +: PB]  = PB'(d_phys[i]);
                e_free[i*PB +: PB]  = PB'(p_phys[i]);
            end
        end
        chk("num_retiring", 64'(num_retiring), 64'(n));
        chk("map_we", 64'(map_we), 64'(e_we));
        chk("map_arch", 64'(map_arch), 64'(e_arch));
        chk("map_phys", 64'(map_phys), 64'(e_phys));
        chk("free_valid", 64'(free_valid), 64'(e_we));
        chk("free_phys", 64'(free_phys), 64'(e_free));
        if (m_known) begin
            chk("flush", 64'(flush), 64'(m_flush));
            chk("redirect_pc", 64'(redirect_pc), 64'(m_pc));
            chk("halted", 64'(halted), 64'(m_halted));
`ifdef RETIRE_PERF_CNT_EN
            chk("retired_count", retired_count, m_ret);
            chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`else
            chk("retired_count", retired_count, 64'd0);
            chk("stall_cycles", 64'(stall_cycles), 64'd0);
`endif
        end
    endtask

    task automatic advance();
        int          n, nm, nr;
        bit          hev, mev;
        logic [31:0] pc, npc, nst;
        logic        nf, nh;
        logic [63:0] nret;
        bit          rst;
        n    = model_retire(hev, mev, pc);
        rst  = reset;
        nm = m_mode; nr = m_rec; nf = 1'b0; nh = m_halted; npc = m_pc; nret = m_ret; nst = m_stall;
        if (rst) begin
            nm = 0; nr = 0; nh = 1'b0; npc = '0; nret = '0; nst = '0;
        end else if (m_mode == 0) begin
            nret = m_ret + 64'(n);
            if (v > 0 && n == 0) nst = m_stall + 32'd1;
            if (hev) begin
                nm = 2; nh = 1'b1;
            end else if (mev) begin
                nm = 1; nr = RC; nf = 1'b1; npc = pc;
            end
        end else if (m_mode == 1) begin
            nr = m_rec - 1;
            if (nr == 0) nm = 0;
        end
        @(posedge clock);
        #1;
        m_mode = nm; m_rec = nr; m_flush = nf; m_halted = nh; m_pc = npc; m_ret = nret; m_stall = nst;
        if (rst) m_known = 1'b1;
    endtask

    task automatic cyc();
        check_now();
        advance();
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_dest(i, 0, 0, 0, 32'h0);
        drive(0, 3'b000, 3'b000, 3'b000);
        cyc();
        cyc();

        // full-width retire with destinations 1/2/3
        reset = 1'b0;
        set_dest(0, 1, 10, 20, 32'h0);
        set_dest(1, 2, 11, 21, 32'h100);
        set_dest(2, 3, 12, 22, 32'h200);
        drive(3, 3'b111, 3'b000, 3'b000);
        check_now();
        chk("r033_n", 64'(num_retiring), 64'd3);
        chk("r033_we", 64'(map_we), 64'b111);
        chk("r033_free", 64'(free_phys), 64'({6'd22, 6'd21, 6'd20}));
        advance();

        // hole at slot 1 stops retirement
        drive(3, 3'b101, 3'b000, 3'b000);
        check_now();
        chk("r034_n", 64'(num_retiring), 64'd1);
        advance();

        // mispredict in slot 1: flush, recover two cycles, resume
        drive(3, 3'b111, 3'b010, 3'b000);
        check_now();
        chk("r035_n", 64'(num_retiring), 64'd2);
        advance();
        drive(3, 3'b111, 3'b000, 3'b000);
        check_now();
        chk("r035_flush", 64'(flush), 64'd1);
        chk("r035_pc", 64'(redirect_pc), 64'h100);
        chk("r035_rec1", 64'(num_retiring), 64'd0);
        advance();
        check_now();
        chk("r035_rec2", 64'(num_retiring), 64'd0);
        chk("r035_pc_hold", 64'(redirect_pc), 64'h100);
        advance();
        check_now();
        chk("r035_resume", 64'(num_retiring), 64'd3);
        advance();

        // halt in slot 0 with no destination
        set_dest(0, 0, 10, 20, 32'h0);
        drive(2, 3'b011, 3'b000, 3'b001);
        check_now();
        chk("r036_n", 64'(num_retiring), 64'd1);
        chk("r036_we", 64'(map_we), 64'd0);
        advance();
        drive(3, 3'b111, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) begin
            check_now();
            chk("r036_halted", 64'(halted), 64'd1);
            chk("r036_n0", 64'(num_retiring), 64'd0);
            advance();
        end

        // reset during recovery
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        set_dest(0, 4, 13, 23, 32'h44);
        drive(1, 3'b001, 3'b001, 3'b000);
        cyc();
        reset = 1'b1;
        drive(3, 3'b111, 3'b000, 3'b000);
        check_now();
        chk("r037_rst_n", 64'(num_retiring), 64'd0);
        advance();
        reset = 1'b0;
        drive(1, 3'b001, 3'b000, 3'b000);
        check_now();
        chk("r037_flush", 64'(flush), 64'd0);
        chk("r037_n", 64'(num_retiring), 64'd1);
        chk("r037_ret", retired_count, 64'd0);
        advance();

        // stall then burst for the counters
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        drive(1, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++) cyc();
        drive(3, 3'b111, 3'b000, 3'b000);
        cyc();
        drive(0, 3'b000, 3'b000, 3'b000);
        check_now();
`ifdef RETIRE_PERF_CNT_EN
        chk("r038_stall", 64'(stall_cycles), 64'd4);
        chk("r038_ret", retired_count, 64'd3);
`else
        chk("r038_stall", 64'(stall_cycles), 64'd0);
        chk("r038_ret", retired_count, 64'd0);
`endif
        advance();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            bit [2:0] c, m, h;
            reset = ($urandom_range(0, 39) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                c[i] = ($urandom_range(0, 3) != 0);
                m[i] = ($urandom_range(0, 7) == 0);
                h[i] = ($urandom_range(0, 31) == 0);
                set_dest(i, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
                         int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), $urandom);
            end
            drive(int'($urandom_range(0, 3)), c, m, h);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 SHALL have parameter N, default 3, retire width (slot 0 = oldest ROB head entry).
REQ-002 SHALL have parameter ARCH_BITS, default 5, architectural register index width.
REQ-003 SHALL have parameter PHYS_BITS, default 6, physical register index width.
REQ-004 SHALL have parameter RECOVER_CYCLES, default 2, retire-blocked cycles after a flush; legal range 1..15.
REQ-005 SHALL define local CNT_BITS = $clog2(N+1).
REQ-006 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-007 Port: reset  in  1  synchronous, active-high reset.
REQ-008 Port: rob_outputs_valid  in  CNT_BITS  count of valid head slots, packed from slot 0.
REQ-009 Port: head_complete, head_mispredict, head_halt  in  N each  per-slot status bits.
REQ-010 Port: head_dest_arch  in  N*ARCH_BITS  per-slot destination architectural register; 0 = no destination.
REQ-011 Port: head_dest_phys, head_prev_phys  in  N*PHYS_BITS each  per-slot new and previous physical register.
REQ-012 Port: head_target_pc  in  N*32  per-slot resolved branch target.
REQ-013 Port: num_retiring  out  CNT_BITS  number of entries the ROB frees this cycle.
REQ-014 Port: map_we  out  N; map_arch  out  N*ARCH_BITS; map_phys  out  N*PHYS_BITS  architectural map table writes.
REQ-015 Port: free_valid  out  N; free_phys  out  N*PHYS_BITS  registers returned to the free list.
REQ-016 Port: flush  out  1; redirect_pc  out  32  pipeline flush pulse and fetch redirect.
REQ-017 Port: halted  out  1  processor halted.
REQ-018 Port: retired_count  out  64; stall_cycles  out  32  performance counters.

Function
REQ-019 SHALL implement FSM states RUN, RECOVER, HALTED.
REQ-020 In RUN, num_retiring SHALL be combinational (0-cycle latency): the count of leading slots i < min(rob_outputs_valid, N) with head_complete[i]=1, stopping at the first incomplete slot.
REQ-021 Scanning SHALL include, then stop after, the first retiring slot with head_mispredict or head_halt set; younger slots do not retire that cycle.
REQ-022 num_retiring SHALL never exceed rob_outputs_valid; rob_outputs_valid > N SHALL be treated as N.
REQ-023 For each retiring slot with head_dest_arch != 0: map_we=1, map_arch/map_phys = dest_arch/dest_phys, free_valid=1, free_phys = prev_phys, all same cycle; all other slots SHALL drive 0.
REQ-024 Multiple retiring slots writing the same arch register SHALL all be presented; the consumer gives the highest slot index priority.
REQ-025 Mispredict retired in cycle T (no halt in same slot): flush=1 for exactly cycle T+1, redirect_pc = that slot's head_target_pc, state RECOVER from T+1.
REQ-026 RECOVER SHALL last exactly RECOVER_CYCLES cycles (4-bit down-counter), then return to RUN; num_retiring=0, map_we=0, free_valid=0 throughout.
REQ-027 Halt retired in cycle T: state HALTED and halted=1 from T+1 until reset; num_retiring=0 in HALTED; halt takes priority over mispredict in the same slot (no flush).
REQ-028 redirect_pc SHALL hold its last value when flush=0.
REQ-029 stall_cycles SHALL increment each RUN cycle with rob_outputs_valid>0 and num_retiring=0; retired_count SHALL add num_retiring each cycle; both wrap on overflow.

Reset
REQ-030 On reset: state RUN, flush=0, redirect_pc=0, halted=0, recovery counter=0, retired_count=0, stall_cycles=0.
REQ-031 Reset SHALL override any simultaneous retire, flush or halt; num_retiring=0 during the reset cycle.

Configuration
REQ-032 Macro RETIRE_PERF_CNT_EN: defined -> retired_count and stall_cycles implemented per REQ-029; undefined -> no counter flops, both outputs tied to 0.

Verification
REQ-033 N=3, valid=3, complete=111, dests 1/2/3 -> num_retiring=3, map_we=111, free_phys = prev_phys per slot, same cycle.
REQ-034 valid=3, complete=101 -> num_retiring=1; slot 2 not retired.
REQ-035 valid=3, complete=111, mispredict slot 1, target 0x100 -> num_retiring=2; next cycle flush=1, redirect_pc=0x100; next 2 cycles num_retiring=0 despite valid heads; then retire resumes.
REQ-036 valid=2, complete=11, halt slot 0, dest_arch slot 0 = 0 -> num_retiring=1, map_we=000; halted=1 from next cycle onward with num_retiring=0.
REQ-037 Reset asserted during RECOVER -> next cycle state RUN, flush=0, counters 0; valid=1 complete=1 then retires 1.
REQ-038 With RETIRE_PERF_CNT_EN: 4 cycles valid=1 complete=0 then 1 cycle retiring 3 -> stall_cycles=4, retired_count=3.
